riscv_hpm_counters: RTL and testbench

RISCV_HPM_COUNTERS -- requirements
Module: riscv_hpm_counters

---
 rtl/riscv_hpm_counters.sv | 159 +++++++++++++++
 tb/tb_riscv_hpm_counters.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_hpm_counters.sv
// Hardware performance monitor: N_CNT event counters with CSR access,
// per-counter event selection, sticky overflow flags and an overflow interrupt.
module riscv_hpm_counters #(
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 48,
  parameter int N_EVENTS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                irq_o
);

  localparam int EW = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;
  localparam int HW = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt      [N_CNT];
  logic [CNT_WIDTH-1:0] cnt_next [N_CNT];
  logic [EW-1:0]        evsel    [N_CNT];
  logic [N_EVENTS-1:0]  ev_q;
  logic [2:0]           ctrl;
  logic [N_CNT-1:0]     ovf, ovfie, ovf_set, ovf_next, ovfie_next;
  logic [N_CNT-1:0]     sel_lo, sel_hi, sel_evsel, wr_lo, wr_hi, wr_evsel, inc;
  logic                 sel_ctrl, sel_ovf, sel_ovfie, mapped;
  logic                 wr_en, wr_ctrl, wr_ovf, wr_ovfie, frozen;
  logic [31:0]          rd, wval;

  // Address decode and read mux; all reads see pre-edge register values.
  always_comb begin
    mapped    = 1'b0;
    rd        = '0;
    sel_lo    = '0;
    sel_hi    = '0;
    sel_evsel = '0;
    sel_ctrl  = 1'b0;
    sel_ovf   = 1'b0;
    sel_ovfie = 1'b0;
    for (int k = 0; k < N_CNT; k++) begin
      if (csr_addr_i == 12'(12'h780 + k)) begin
        mapped    = 1'b1;
        sel_lo[k] = 1'b1;
        rd        = cnt[k][31:0];
      end
      if (csr_addr_i == 12'(12'h790 + k)) begin
        mapped    = 1'b1;
        sel_hi[k] = 1'b1;
        rd        = 32'(cnt[k][CNT_WIDTH-1:32]);
      end
      if (csr_addr_i == 12'(12'h7B0 + k)) begin
        mapped       = 1'b1;
        sel_evsel[k] = 1'b1;
        rd           = 32'(evsel[k]);
      end
    end
    if (csr_addr_i == 12'h7A1) begin
      mapped   = 1'b1;
      sel_ctrl = 1'b1;
      rd       = 32'(ctrl);
    end
    if (csr_addr_i == 12'h7A2) begin
      mapped  = 1'b1;
      sel_ovf = 1'b1;
      rd      = 32'(ovf);
    end
    if (csr_addr_i == 12'h7A3) begin
      mapped    = 1'b1;
      sel_ovfie = 1'b1;
      rd        = 32'(ovfie);
    end
  end

  assign csr_hit_o   = csr_access_i & mapped;
  assign csr_rdata_o = csr_hit_o ? rd : 32'h0;

  always_comb begin
    case (csr_op_i)
      2'b10:   wval = csr_wdata_i | csr_rdata_o;
      2'b11:   wval = csr_rdata_o & ~csr_wdata_i;
      default: wval = csr_wdata_i;
    endcase
  end

  assign wr_en    = csr_hit_o & (csr_op_i != 2'b00);
  assign wr_lo    = sel_lo & {N_CNT{wr_en}};
  assign wr_hi    = sel_hi & {N_CNT{wr_en}};
  assign wr_evsel = sel_evsel & {N_CNT{wr_en}};
  assign wr_ctrl  = sel_ctrl & wr_en;
  assign wr_ovf   = sel_ovf & wr_en;
  assign wr_ovfie = sel_ovfie & wr_en;

  assign frozen = ctrl[2] & (|ovf);

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    logic                 ev_hit, all_ones, ovf_hit;
    logic [CNT_WIDTH-1:0] nxt;

    // Selector values past the last event input count nothing.
    assign ev_hit   = (int'(evsel[gi]) < N_EVENTS) && ev_q[evsel[gi]];
    assign all_ones = &cnt[gi];
    assign inc[gi]  = ctrl[0] & ~frozen & ev_hit;

    // A CSR write to either half wins over a same-cycle increment and its overflow.
    always_comb begin
      nxt     = cnt[gi];
      ovf_hit = 1'b0;
      if (wr_lo[gi]) begin
        nxt[31:0] = wval;
      end else if (wr_hi[gi]) begin
        nxt[CNT_WIDTH-1:32] = wval[HW-1:0];
      end else if (inc[gi]) begin
        ovf_hit = all_ones;
        if (!all_ones)
          nxt = cnt[gi] + 1'b1;
        else if (!ctrl[1])
          nxt = '0;
      end
    end

    assign cnt_next[gi] = nxt;
    assign ovf_set[gi]  = ovf_hit;
  end

  // Hardware overflow set takes priority over a CSR clear of the same bit.
  assign ovf_next   = (wr_ovf ? wval[N_CNT-1:0] : ovf) | ovf_set;
  assign ovfie_next = wr_ovfie ? wval[N_CNT-1:0] : ovfie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_q  <= '0;
      ctrl  <= 3'b001;
      ovf   <= '0;
      ovfie <= '0;
      irq_o <= 1'b0;
      for (int k = 0; k < N_CNT; k++) begin
        cnt[k]   <= '0;
        evsel[k] <= EW'(k % N_EVENTS);
      end
    end else begin
      ev_q  <= events_i;
      ovf   <= ovf_next;
      ovfie <= ovfie_next;
      irq_o <= |(ovf_next & ovfie_next);
      if (wr_ctrl)
        ctrl <= wval[2:0];
      for (int k = 0; k < N_CNT; k++) begin
        cnt[k] <= cnt_next[k];
        if (wr_evsel[k])
          evsel[k] <= wval[EW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_riscv_hpm_counters.sv
// Self-checking bench for riscv_hpm_counters: CSR reads are queued with their
// expected values and compared when the read data is sampled.
module tb_riscv_hpm_counters;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_access = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [15:0] events = '0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        hit;
  } exp_t;
  exp_t sb[$];

  riscv_hpm_counters dut (
    .clk         (clk),
    .rst         (rst),
    .csr_access_i(csr_access),
    .csr_addr_i  (csr_addr),
    .csr_wdata_i (csr_wdata),
    .csr_op_i    (csr_op),
    .csr_rdata_o (csr_rdata),
    .csr_hit_o   (csr_hit),
    .events_i    (events),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    @(posedge clk); #1;
    csr_access = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d;
    @(posedge clk); #1;
    csr_access = 1'b0; csr_op = 2'b00;
    $display("[TB] wr addr=%h op=%0d data=%h", a, op, d);
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp,
                          input logic exp_hit = 1'b1);
    exp_t e;
    e.tag = tag; e.data = exp; e.hit = exp_hit;
    sb.push_back(e);
    csr_access = 1'b1; csr_addr = a; csr_op = 2'b00;
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_hit"}, 32'(csr_hit), 32'(e.hit));
    check(e.tag, csr_rdata, e.data);
    $display("[TB] rd %s addr=%h data=%h hit=%0b", e.tag, a, csr_rdata, csr_hit);
    csr_access = 1'b0;
  endtask

  initial begin
    // Reset values
    rd_check("rst_ctrl", 12'h7A1, 32'h1);
    rd_check("rst_evsel1", 12'h7B1, 32'h1);
    rd_check("rst_evsel3", 12'h7B3, 32'h3);
    rd_check("rst_ovf", 12'h7A2, 32'h0);
    rd_check("rst_cnt0", 12'h780, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Five event pulses on counter 0, one cycle of latency through ev_q
    @(posedge clk); #1 events = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 4) events = '0;
      rd_check("cnt0_lat", 12'h780, 32'(i));
    end
    repeat (2) @(posedge clk); #1;
    rd_check("cnt0_lo", 12'h780, 32'h5);
    rd_check("cnt0_hi", 12'h790, 32'h0);
    rd_check("cnt1_idle", 12'h781, 32'h0);

    // Wrap from all-ones with interrupt
    csr_write(12'h781, 2'b01, 32'hFFFF_FFFF);
    csr_write(12'h791, 2'b01, 32'h0000_FFFF);
    csr_write(12'h7A3, 2'b01, 32'h2);
    rd_check("cnt1_hi_pre", 12'h791, 32'h0000_FFFF);
    @(posedge clk); #1 events = 16'h0002;
    @(posedge clk); #1 events = '0;
    @(negedge clk);
    check("irq_before", 32'(irq), 32'h0);
    @(posedge clk); @(negedge clk);
    check("irq_wrap", 32'(irq), 32'h1);
    rd_check("cnt1_wrap_lo", 12'h781, 32'h0);
    rd_check("cnt1_wrap_hi", 12'h791, 32'h0);
    rd_check("ovf_wrap", 12'h7A2, 32'h2);
    csr_write(12'h7A2, 2'b11, 32'h2);
    check("irq_clr", 32'(irq), 32'h0);
    rd_check("ovf_clr", 12'h7A2, 32'h0);

    // Saturate + freeze-on-overflow
    csr_write(12'h781, 2'b01, 32'hFFFF_FFFF);
    csr_write(12'h791, 2'b01, 32'h0000_FFFF);
    csr_write(12'h7A1, 2'b01, 32'h7);
    events = 16'h0003;
    repeat (5) @(posedge clk); #1;
    events = '0;
    repeat (2) @(posedge clk); #1;
    rd_check("sat_lo", 12'h781, 32'hFFFF_FFFF);
    rd_check("sat_hi", 12'h791, 32'h0000_FFFF);
    rd_check("sat_ovf", 12'h7A2, 32'h2);
    rd_check("frozen_cnt0", 12'h780, 32'h6);
    check("sat_irq", 32'(irq), 32'h1);

    // Sticky overflow: hardware set beats a same-cycle CSR clear
    csr_write(12'h7A1, 2'b01, 32'h3);
    events = 16'h0002;
    repeat (3) @(posedge clk);
    csr_write(12'h7A2, 2'b11, 32'h2);
    rd_check("ovf_setwins", 12'h7A2, 32'h2);
    events = '0;
    repeat (3) @(posedge clk);
    csr_write(12'h7A2, 2'b11, 32'h2);
    rd_check("ovf_clr2", 12'h7A2, 32'h0);
    rd_check("sat_hold_lo", 12'h781, 32'hFFFF_FFFF);
    check("irq_clr2", 32'(irq), 32'h0);

    // CSR write beats same-cycle increment
    events = 16'h0004;
    repeat (4) @(posedge clk);
    csr_write(12'h782, 2'b01, 32'h10);
    rd_check("wr_wins", 12'h782, 32'h10);
    events = '0;
    repeat (3) @(posedge clk);
    csr_write(12'h792, 2'b01, 32'h1234);
    rd_check("cnt2_lo_kept", 12'h782, 32'h11);
    rd_check("cnt2_hi", 12'h792, 32'h1234);

    // Unmapped addresses, truncation, set/clear ops
    rd_check("unmapped_784", 12'h784, 32'h0, 1'b0);
    rd_check("unmapped_7a0", 12'h7A0, 32'h0, 1'b0);
    csr_write(12'h7B0, 2'b01, 32'h1F);
    rd_check("evsel_trunc", 12'h7B0, 32'hF);
    csr_write(12'h7B0, 2'b01, 32'h0);
    csr_write(12'h7B3, 2'b01, 32'h7);
    csr_write(12'h7A1, 2'b01, 32'hFF);
    rd_check("ctrl_trunc", 12'h7A1, 32'h7);
    csr_write(12'h7A1, 2'b01, 32'h1);
    csr_write(12'h7A3, 2'b10, 32'h1);
    rd_check("ovfie_set", 12'h7A3, 32'h3);
    csr_write(12'h7A3, 2'b11, 32'h2);
    rd_check("ovfie_clr", 12'h7A3, 32'h1);
    csr_access = 1'b0; csr_addr = 12'h780; #1;
    check("noaccess_hit", 32'(csr_hit), 32'h0);
    check("noaccess_data", csr_rdata, 32'h0);

    // Asynchronous reset while counting with the interrupt asserted
    csr_write(12'h7A2, 2'b01, 32'h1);
    events = 16'h000F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("irq_prerst", 32'(irq), 32'h1);
    #2 rst = 1'b1;
    csr_access = 1'b1; csr_addr = 12'h780; #1;
    check("arst_cnt0", csr_rdata, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    csr_addr = 12'h7A1; #1;
    check("arst_ctrl", csr_rdata, 32'h1);
    csr_addr = 12'h7B3; #1;
    check("arst_evsel3", csr_rdata, 32'h3);
    csr_addr = 12'h7A3; #1;
    check("arst_ovfie", csr_rdata, 32'h0);
    csr_addr = 12'h782; #1;
    check("arst_cnt2", csr_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    csr_access = 1'b0;
    rd_check("post_rst0", 12'h780, 32'h0);
    @(posedge clk); #1;
    rd_check("post_rst1", 12'h780, 32'h0);
    @(posedge clk); #1;
    rd_check("post_rst2", 12'h780, 32'h1);
    events = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
